// File: rtl/mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_pkg                                                         |
// | Purpose  : Shared FSM state encoding and default sizing for mac_accum.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mac_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_LEN   = 16;
  localparam int DEF_ACC_W = 2 * DEF_N + 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_accum_sat_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sat_add                                                         |
// | Purpose  : ACC_W-bit adder; clamps to all-ones and flags carry-out when    |
// |            MAC_ACCUM_SAT_EN is defined, otherwise wraps with ovf tied 0.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

`ifdef MAC_ACCUM_SAT_EN
  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
  assign o_ovf  = w_full[W];
`else
  assign o_sum  = i_a + i_b;
  assign o_ovf  = 1'b0;
`endif

endmodule : sat_add
`default_nettype wire

// File: rtl/mac_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_accum                                                       |
// | Purpose  : Accumulates LEN unsigned products into an ACC_W-bit sum with a  |
// |            valid/ready result port. Optional saturation: MAC_ACCUM_SAT_EN. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mac_accum
  import mac_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int LEN   = DEF_LEN,
  parameter int ACC_W = 2 * N + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             p_valid,
  input  logic [2*N-1:0]   p_in,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  localparam int CW = $clog2(LEN + 1);

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [ACC_W-1:0] w_p_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;

  assign busy      = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign p_ready   = busy & ~start;
  assign acc_out   = r_acc;
  assign ovf       = r_ovf;

  assign w_accept  = p_valid & p_ready;
  assign w_last    = w_accept & (r_count == CW'(LEN - 1));
  assign w_p_ext   = ACC_W'(p_in);

  sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (w_p_ext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // start overrides every state, including an unacknowledged DONE
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = ACCUM;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        ACCUM:   if (w_last) w_next = DONE;
        DONE:    if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (start) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_sum;
      r_count <= r_count + CW'(1);
      r_ovf   <= r_ovf | w_add_ovf;
    end
  end

endmodule : mac_accum
`default_nettype wire

// File: tb/tb_mac_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mac_accum                                                    |
// | Purpose  : Directed scoreboard bench for mac_accum (N=8, LEN=4, ACC_W=16). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mac_accum;

  localparam int N     = 8;
  localparam int LEN   = 4;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             p_valid;
  logic [2*N-1:0]   p_in;
  logic             p_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             ovf;

  int               n_vec  = 0;
  int               n_fail = 0;
  logic [ACC_W-1:0] q_acc[$];
  logic             q_ovf[$];

  mac_accum #(
    .N     (N),
    .LEN   (LEN),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .p_valid   (p_valid),
    .p_in      (p_in),
    .p_ready   (p_ready),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_result(input logic [ACC_W-1:0] a, input logic o);
    q_acc.push_back(a);
    q_ovf.push_back(o);
  endtask

  // Monitor: pops an expected result on every result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q_acc.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_result: got acc %0d, expected no result", acc_out);
      end else begin
        check("result_acc", 32'(acc_out), 32'(q_acc.pop_front()));
        check("result_ovf", 32'(ovf), 32'(q_ovf.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Caller is always positioned 1ns after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    check("start_blocks_ready", 32'(p_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic burst4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    logic [15:0] v[4];
    v = '{a, b, c, d};
    p_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p_in = v[i];
      @(negedge clk);
      check("burst_ready", 32'(p_ready), 32'd1);
      if (i == 3) check("no_early_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    p_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [15:0] v);
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #1;
      check("gap_busy", 32'(busy), 32'd1);
    end
    p_valid = 1'b1;
    p_in    = v;
    @(negedge clk);
    check("gap_ready", 32'(p_ready), 32'd1);
    @(posedge clk); #1;
    p_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    p_valid   = 1'b0;
    p_in      = '0;
    out_ready = 1'b0;
    #12;
    check("rst_acc",   32'(acc_out),   32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(p_ready),   32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Back-to-back, consumer ready early
    out_ready = 1'b1;
    expect_result(16'd100, 1'b0);
    pulse_start();
    burst4(16'd10, 16'd20, 16'd30, 16'd40);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_acc",   32'(acc_out),   32'd100);
    check("b2b_ovf",   32'(ovf),       32'd0);
    @(posedge clk); #1;
    check("b2b_idle", 32'(out_valid), 32'd0);

    // Gapped input
    expect_result(16'd100, 1'b0);
    pulse_start();
    send_gap(16'd10);
    send_gap(16'd20);
    send_gap(16'd30);
    send_gap(16'd40);
    check("gap_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Back-pressure in DONE with stray p_valid
    out_ready = 1'b0;
    pulse_start();
    burst4(16'd10, 16'd20, 16'd30, 16'd40);
    for (int k = 0; k < 5; k++) begin
      p_valid = 1'b1;
      p_in    = 16'd99;
      @(negedge clk);
      check("hold_acc",   32'(acc_out),   32'd100);
      check("hold_ready", 32'(p_ready),   32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    p_valid = 1'b0;
    expect_result(16'd100, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_idle_valid", 32'(out_valid), 32'd0);
    check("hold_idle_busy",  32'(busy),      32'd0);

    // Restart mid-accumulation
    expect_result(16'd4, 1'b0);
    pulse_start();
    send_gap(16'd5);
    send_gap(16'd5);
    pulse_start();
    check("restart_acc", 32'(acc_out), 32'd0);
    burst4(16'd1, 16'd1, 16'd1, 16'd1);
    check("restart_final", 32'(acc_out), 32'd4);
    @(posedge clk); #1;

    // Restart from an unacknowledged DONE
    out_ready = 1'b0;
    pulse_start();
    burst4(16'd2, 16'd2, 16'd2, 16'd2);
    check("done_acc", 32'(acc_out), 32'd8);
    pulse_start();
    check("done_restart_valid", 32'(out_valid), 32'd0);
    check("done_restart_busy",  32'(busy),      32'd1);
    check("done_restart_acc",   32'(acc_out),   32'd0);
    expect_result(16'd12, 1'b0);
    out_ready = 1'b1;
    burst4(16'd3, 16'd3, 16'd3, 16'd3);
    @(posedge clk); #1;

    // Overflow behaviour
`ifdef MAC_ACCUM_SAT_EN
    expect_result(16'd65535, 1'b1);
`else
    expect_result(16'd64514, 1'b0);
`endif
    pulse_start();
    burst4(16'd65025, 16'd65025, 16'd0, 16'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-accumulation
    pulse_start();
    send_gap(16'd7);
    send_gap(16'd7);
    check("pre_rst_acc", 32'(acc_out), 32'd14);
    rst_n = 1'b0;
    #1;
    check("arst_acc",   32'(acc_out),   32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_ready", 32'(p_ready),   32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ovf",   32'(ovf),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    p_valid = 1'b1;
    p_in    = 16'd5;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_rst_busy",  32'(busy),    32'd0);
      check("post_rst_ready", 32'(p_ready), 32'd0);
      check("post_rst_acc",   32'(acc_out), 32'd0);
    end
    p_valid = 1'b0;

    check("queue_drained", 32'(q_acc.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_mac_accum
`default_nettype wire

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter N, default 8, multiplier operand width; product width is 2*N.
REQ-002 SHALL have parameter LEN, default 16, number of products per accumulation (1..255).
REQ-003 SHALL have parameter ACC_W, default 2*N+8, accumulator width (>= 2*N).
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse: clear accumulator and begin a new accumulation.
REQ-007 SHALL have port p_valid  input  1  product on p_in is valid.
REQ-008 SHALL have port p_in  input  2*N  unsigned product from the upstream multiplier output register.
REQ-009 SHALL have port p_ready  output  1  block accepts a product this cycle.
REQ-010 SHALL have port acc_out  output  ACC_W  accumulated sum, held while out_valid is high.
REQ-011 SHALL have port out_valid  output  1  acc_out holds a completed result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port busy  output  1  high in the ACCUM state.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag for the current accumulation.

Function
REQ-015 SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-016 SHALL drive p_ready high only in ACCUM and never in a cycle where start is high.
REQ-017 SHALL accept a product when p_valid and p_ready are both high, adding zero-extended p_in to the accumulator and incrementing the term counter.
REQ-018 SHALL transition ACCUM->DONE on the edge that accepts the LEN-th product; out_valid and the final acc_out SHALL appear the next cycle, giving 1-cycle latency from the last accepted product.
REQ-019 SHALL hold acc_out and ovf stable in DONE until out_valid and out_ready are both high, then go to IDLE.
REQ-020 SHALL allow out_ready to be high before out_valid; it has no effect outside DONE.
REQ-021 SHALL, when start is high in any state, clear acc, count and ovf, drop out_valid and enter ACCUM on that edge; start SHALL take priority over p_valid and out_ready.
REQ-022 SHALL ignore p_valid in IDLE and DONE; there are no side effects.
REQ-023 SHALL accumulate with gaps: p_valid low for any number of cycles in ACCUM SHALL leave state unchanged.
REQ-024 SHALL use a term counter of width $clog2(LEN+1) that never wraps.

Reset
REQ-025 SHALL, on rst_n low, asynchronously enter IDLE with acc_out=0, out_valid=0, p_ready=0, busy=0, ovf=0 and counter=0.
REQ-026 SHALL discard any partial accumulation on reset mid-ACCUM; the first cycle after deassertion is IDLE.

Configuration
REQ-027 SHALL, with macro MAC_ACCUM_SAT_EN defined, clamp the accumulator at 2^ACC_W-1 on overflow and set ovf, which stays set until the next start or reset.
REQ-028 SHALL, without MAC_ACCUM_SAT_EN, wrap the accumulator modulo 2^ACC_W and tie ovf to 0.

Structure
REQ-029 SHALL place the FSM state enum (IDLE/ACCUM/DONE) and default N/LEN/ACC_W localparams in a shared package mac_pkg.
REQ-030 SHALL isolate the add path in one sub-module sat_add (ACC_W-bit add, saturation under MAC_ACCUM_SAT_EN, carry-out to ovf).

Verification
REQ-031 SHALL verify (N=8, LEN=4): start, then products 10,20,30,40 back-to-back -> out_valid one cycle after the 4th accept, acc_out=100, ovf=0.
REQ-032 SHALL verify: same four products with p_valid gaps of 3 idle cycles -> acc_out=100 and busy high throughout.
REQ-033 SHALL verify: out_ready low for 5 cycles in DONE -> acc_out stays 100, p_ready=0, extra p_valid ignored; out_ready high -> IDLE next cycle.
REQ-034 SHALL verify: start asserted after 2 products (5,5), then 1,1,1,1 -> acc_out=4.
REQ-035 SHALL verify (ACC_W=16, SAT_EN): products 65025 x2 -> acc_out=65535 and ovf=1; without macro -> acc_out=64514 and ovf=0.
REQ-036 SHALL verify: rst_n pulsed low mid-ACCUM -> all outputs 0 immediately and IDLE after release.
